jpeg_rle_dezigzag: RTL and testbench

Decoder-side counterpart of the encoder's zigzag buffer and Huffman run/size stage. Accepts already-Huffman-decoded symbols: one DC symbol, then AC symbols carrying zero-run, size category and raw amplitude bits. It rebuilds the 8x8 block of quantized coefficients in natural row-major order and presents it as a 512-bit word, ready for the dequantize/IDCT path.

---
 rtl/jpeg_pkg.sv | 33 +++
 rtl/jpeg_amp_decode.sv | 54 +++++
 rtl/jpeg_rle_dezigzag.sv | 178 +++++++++++++++++
 tb/tb_jpeg_rle_dezigzag.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions: FSM states, special run/size symbols and the
// zigzag-to-natural coefficient order used by both encoder and decoder.
package jpeg_pkg;

  typedef enum logic [1:0] {
    S_DC  = 2'd0,
    S_AC  = 2'd1,
    S_OUT = 2'd2
  } state_e;

  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;
  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] MAX_SIZE = 4'd11;

  localparam logic [5:0] ZZ2NAT_LUT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Map a zigzag scan position to its row-major (row*8+col) index.
  function automatic logic [5:0] zz2nat(input logic [5:0] zz);
    return ZZ2NAT_LUT[zz];
  endfunction

endpackage

// File: rtl/jpeg_amp_decode.sv
// Combinational JPEG amplitude decode: size category plus raw bits to a
// signed value, saturated for AC use and added to the DC predictor.
module jpeg_amp_decode #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]            size,
  input  logic [10:0]           amp,
  input  logic [DATA_WIDTH-1:0] pred,
  output logic [DATA_WIDTH-1:0] ac_val,
  output logic [DATA_WIDTH-1:0] dc_val
);
  import jpeg_pkg::*;

  localparam int MAXV = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [13:0] SAT_MAX = 14'(MAXV);
  localparam logic signed [13:0] SAT_MIN = 14'(-MAXV - 1);

  // Clamp a wide signed value into the coefficient range.
  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [13:0] x);
    logic signed [13:0] y;
    if (x > SAT_MAX) begin
      y = SAT_MAX;
    end else if (x < SAT_MIN) begin
      y = SAT_MIN;
    end else begin
      y = x;
    end
    return y[DATA_WIDTH-1:0];
  endfunction

  logic [11:0]        mask;
  logic [11:0]        low;
  logic [11:0]        msb_bits;
  logic signed [12:0] v;
  logic signed [13:0] sum;

  // Decode the amplitude: a clear top bit marks a negative value.
  always_comb begin
    mask     = (12'd1 << size) - 12'd1;
    low      = {1'b0, amp} & mask;
    msb_bits = {1'b0, amp} >> (size - 4'd1);
    if ((size == 4'd0) || (size > MAX_SIZE)) begin
      v = 13'sd0;
    end else if (msb_bits[0]) begin
      v = $signed({1'b0, low});
    end else begin
      v = $signed({1'b0, low}) - $signed({1'b0, mask});
    end
    sum    = 14'($signed(pred)) + 14'(v);
    ac_val = sat(14'(v));
    dc_val = sat(sum);
  end

endmodule

// File: rtl/jpeg_rle_dezigzag.sv
// Decoder-side run-length expansion and de-zigzag: rebuilds an 8x8 block of
// quantized coefficients in row-major order from decoded DC/AC symbols.
module jpeg_rle_dezigzag #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dc_pred_clear,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic                          sym_is_dc,
  input  logic [3:0]                    sym_run,
  input  logic [3:0]                    sym_size,
  input  logic [10:0]                   sym_amp,
  output logic                          block_valid,
  input  logic                          block_ready,
  output logic [DEPTH*DATA_WIDTH-1:0]   block_out,
  output logic                          error
);
  import jpeg_pkg::*;

  state_e                state, state_next;
  logic [6:0]            pos, pos_next;
  logic [DATA_WIDTH-1:0] pred;
  logic [DATA_WIDTH-1:0] pred_in;
  logic [DATA_WIDTH-1:0] ac_val;
  logic [DATA_WIDTH-1:0] dc_val;
  logic                  accept;
  logic                  size_bad;
  logic                  err_next;
  logic                  coef_we;
  logic [5:0]            coef_idx;
  logic [DATA_WIDTH-1:0] coef_val;
  logic                  pred_we;
  logic                  clear_blk;
  logic [6:0]            zrl_pos;
  logic [6:0]            t_pos;

  // A restart clear takes effect before the DC symbol of the same cycle.
  assign pred_in   = dc_pred_clear ? '0 : pred;
  assign sym_ready = (state != S_OUT);
  assign block_valid = (state == S_OUT);
  assign accept    = sym_valid && sym_ready;
  assign size_bad  = (sym_size > MAX_SIZE);
  assign zrl_pos   = pos + 7'd16;
  assign t_pos     = pos + {3'd0, sym_run};

  jpeg_amp_decode #(.DATA_WIDTH(DATA_WIDTH)) u_amp (
    .size   (sym_size),
    .amp    (sym_amp),
    .pred   (pred_in),
    .ac_val (ac_val),
    .dc_val (dc_val)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_DC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and symbol decisions.
  always_comb begin
    state_next = state;
    pos_next   = pos;
    err_next   = 1'b0;
    coef_we    = 1'b0;
    coef_idx   = 6'd0;
    coef_val   = '0;
    pred_we    = 1'b0;
    clear_blk  = 1'b0;
    case (state)
      S_DC: begin
        if (accept) begin
          if (size_bad || !sym_is_dc) begin
            err_next = 1'b1;
          end else begin
            coef_we    = 1'b1;
            coef_idx   = 6'd0;
            coef_val   = dc_val;
            pred_we    = 1'b1;
            pos_next   = 7'd1;
            state_next = S_AC;
          end
        end else begin
          state_next = S_DC;
        end
      end
      S_AC: begin
        if (accept) begin
          if (size_bad || sym_is_dc) begin
            err_next = 1'b1;
          end else if ((sym_run == EOB_RUN) && (sym_size == EOB_SIZE)) begin
            state_next = S_OUT;
          end else if ((sym_run == ZRL_RUN) && (sym_size == ZRL_SIZE)) begin
            pos_next = zrl_pos;
            if (zrl_pos > 7'd63) begin
              err_next   = 1'b1;
              state_next = S_OUT;
            end else begin
              state_next = S_AC;
            end
          end else if (t_pos > 7'd63) begin
            err_next   = 1'b1;
            state_next = S_OUT;
          end else begin
            coef_we  = 1'b1;
            coef_idx = zz2nat(t_pos[5:0]);
            coef_val = ac_val;
            pos_next = t_pos + 7'd1;
            if (t_pos == 7'd63) begin
              state_next = S_OUT;
            end else begin
              state_next = S_AC;
            end
          end
        end else begin
          state_next = S_AC;
        end
      end
      S_OUT: begin
        if (block_ready) begin
          clear_blk  = 1'b1;
          pos_next   = 7'd0;
          state_next = S_DC;
        end else begin
          state_next = S_OUT;
        end
      end
      default: begin
        state_next = S_DC;
        pos_next   = 7'd0;
      end
    endcase
  end

  // Scan position and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos   <= 7'd0;
      error <= 1'b0;
    end else begin
      pos   <= pos_next;
      error <= err_next;
    end
  end

  // DC predictor, survives block boundaries until cleared or reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred <= '0;
    end else if (pred_we) begin
      pred <= dc_val;
    end else if (dc_pred_clear) begin
      pred <= '0;
    end else begin
      pred <= pred;
    end
  end

  // Coefficient buffer, row-major with index 0 in the top bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      block_out <= '0;
    end else if (clear_blk) begin
      block_out <= '0;
    end else if (coef_we) begin
      block_out[(DEPTH - 1 - int'(coef_idx)) * DATA_WIDTH +: DATA_WIDTH] <= coef_val;
    end else begin
      block_out <= block_out;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_dezigzag.sv
// Self-checking bench for jpeg_rle_dezigzag: directed scenarios plus random
// symbol streams against a behavioural block model.
module tb_jpeg_rle_dezigzag;

  logic         clock = 1'b0;
  logic         reset;
  logic         dc_pred_clear;
  logic         sym_valid;
  logic         sym_ready;
  logic         sym_is_dc;
  logic [3:0]   sym_run;
  logic [3:0]   sym_size;
  logic [10:0]  sym_amp;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_out;
  logic         error;

  always #5 clock = ~clock;

  jpeg_rle_dezigzag #(.DATA_WIDTH(8), .DEPTH(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .dc_pred_clear (dc_pred_clear),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_is_dc     (sym_is_dc),
    .sym_run       (sym_run),
    .sym_size      (sym_size),
    .sym_amp       (sym_amp),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_out     (block_out),
    .error         (error)
  );

  // Behavioural model state
  int zz[64];
  int coef_m[64];
  int pred_m;
  int pos_m;
  bit full_m;     // block complete, waiting for downstream
  bit want_dc_m;  // next accepted symbol must be the DC difference
  bit err_m;
  int n_cmp = 0;
  int n_bad = 0;

  // Build the zigzag order by walking anti-diagonals, alternating direction.
  task automatic build_zigzag();
    int n = 0;
    for (int d = 0; d < 15; d++) begin
      for (int i = 0; i < 8; i++) begin
        int r = (d % 2 == 0) ? (d - i) : i;
        int c = d - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
          zz[n] = r * 8 + c;
          n++;
        end
      end
    end
  endtask

  function automatic int sat8(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int amp_val(int s, int amp);
    int raw;
    if (s == 0) return 0;
    raw = amp & ((1 << s) - 1);
    if (raw >= (1 << (s - 1))) return raw;
    return raw - (1 << s) + 1;
  endfunction

  function automatic logic [511:0] model_block();
    logic [511:0] b = '0;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] c8 = 8'(coef_m[k]);
      b[(63 - k) * 8 +: 8] = c8;
    end
    return b;
  endfunction

  function automatic logic [7:0] dut_coef(int k);
    return block_out[(63 - k) * 8 +: 8];
  endfunction

  task automatic clear_model_block();
    for (int k = 0; k < 64; k++) coef_m[k] = 0;
    pos_m = 0;
  endtask

  // Advance the model by one clock with the inputs currently driven.
  task automatic model_step();
    bit fire;
    bit dc_taken = 1'b0;
    int v;
    int base;
    int t;
    err_m = 1'b0;
    if (reset) begin
      clear_model_block();
      pred_m = 0; full_m = 1'b0; want_dc_m = 1'b1;
      return;
    end
    fire = sym_valid && !full_m;
    v    = amp_val(int'(sym_size), int'(sym_amp));
    base = dc_pred_clear ? 0 : pred_m;
    if (full_m) begin
      if (block_ready) begin
        clear_model_block();
        full_m = 1'b0; want_dc_m = 1'b1;
      end
    end else if (fire) begin
      if (sym_size > 4'd11) begin
        err_m = 1'b1;
      end else if (want_dc_m) begin
        if (!sym_is_dc) err_m = 1'b1;
        else begin
          coef_m[0] = sat8(base + v);
          pred_m = coef_m[0];
          dc_taken = 1'b1;
          pos_m = 1; want_dc_m = 1'b0;
        end
      end else if (sym_is_dc) begin
        err_m = 1'b1;
      end else if (sym_run == 4'd0 && sym_size == 4'd0) begin
        full_m = 1'b1;
      end else if (sym_run == 4'd15 && sym_size == 4'd0) begin
        pos_m += 16;
        if (pos_m > 63) begin err_m = 1'b1; full_m = 1'b1; end
      end else begin
        t = pos_m + int'(sym_run);
        if (t > 63) begin
          err_m = 1'b1; full_m = 1'b1;
        end else begin
          coef_m[zz[t]] = sat8(v);
          pos_m = t + 1;
          if (pos_m == 64) full_m = 1'b1;
        end
      end
    end
    if (dc_pred_clear && !dc_taken) pred_m = 0;
  endtask

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: update the model, then compare all outputs after the edge.
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check("sym_ready",   512'(sym_ready),   512'(!full_m));
    check("block_valid", 512'(block_valid), 512'(full_m));
    check("error",       512'(error),       512'(err_m));
    check("block_out",   block_out,         model_block());
  endtask

  task automatic send(bit dc, int run, int size, int amp);
    sym_valid = 1'b1; sym_is_dc = dc;
    sym_run = 4'(run); sym_size = 4'(size); sym_amp = 11'(amp);
    cycle();
    sym_valid = 1'b0; dc_pred_clear = 1'b0;
  endtask

  task automatic drain();
    block_ready = 1'b1;
    cycle();
    block_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] held;
    build_zigzag();
    clear_model_block();
    pred_m = 0; full_m = 1'b0; want_dc_m = 1'b1; err_m = 1'b0;
    reset = 1'b1; dc_pred_clear = 1'b0; sym_valid = 1'b0; sym_is_dc = 1'b0;
    sym_run = 4'd0; sym_size = 4'd0; sym_amp = 11'd0; block_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    check("rst_ready", 512'(sym_ready), 512'(1));
    check("rst_block", block_out, 512'(0));
    // model pins
    check("zz3", 512'(zz[3]), 512'(16));
    check("zz63", 512'(zz[63]), 512'(63));

    // DC 5 then EOB
    send(1'b1, 0, 3, 5);
    check("dc5", 512'(dut_coef(0)), 512'(8'd5));
    send(1'b0, 0, 0, 0);
    check("eob_valid", 512'(block_valid), 512'(1));
    check("eob_rest", 512'(block_out[503:0]), 512'(0));
    drain();

    // DC -2 with a cleared predictor, then a size-0 DC keeps -2
    dc_pred_clear = 1'b1;
    send(1'b1, 0, 2, 1);
    check("dc_m2", 512'(dut_coef(0)), 512'(8'hFE));
    send(1'b0, 0, 0, 0); drain();
    send(1'b1, 0, 0, 0);
    check("dc_hold", 512'(dut_coef(0)), 512'(8'hFE));
    send(1'b0, 0, 0, 0); drain();
    dc_pred_clear = 1'b1;
    send(1'b1, 0, 1, 1);
    check("dc_clr", 512'(dut_coef(0)), 512'(8'd1));
    send(1'b0, 0, 1, 0);
    check("ac_nat1", 512'(dut_coef(1)), 512'(8'hFF));
    send(1'b0, 1, 2, 3);
    check("ac_nat16", 512'(dut_coef(16)), 512'(8'd3));
    send(1'b0, 0, 0, 0); drain();

    // Three ZRL then run 14 lands on the last coefficient
    send(1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(1'b0, 15, 0, 0);
    send(1'b0, 14, 1, 1);
    check("nat63", 512'(dut_coef(63)), 512'(8'd1));
    check("full_valid", 512'(block_valid), 512'(1));
    drain();

    // Fourth ZRL overflows
    send(1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(1'b0, 15, 0, 0);
    check("zrl_err", 512'(error), 512'(1));
    check("zrl_valid", 512'(block_valid), 512'(1));
    held = block_out;
    for (int i = 0; i < 5; i++) cycle();
    check("hold_block", block_out, held);
    check("hold_ready", 512'(sym_ready), 512'(0));
    drain();

    // AC symbol while a DC is expected
    send(1'b0, 2, 3, 4);
    check("nondc_err", 512'(error), 512'(1));
    check("nondc_ready", 512'(sym_ready), 512'(1));

    // Reset in the middle of a block
    send(1'b1, 0, 4, 9);
    send(1'b0, 0, 2, 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_block", block_out, 512'(0));
    check("mid_rst_valid", 512'(block_valid), 512'(0));

    // Random symbol streams
    for (int n = 0; n < 4000; n++) begin
      int r = int'($urandom_range(0, 99));
      sym_valid     = ($urandom_range(0, 3) != 0);
      sym_is_dc     = want_dc_m ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 8);
      sym_run       = (r < 10) ? 4'd15 : 4'($urandom_range(0, 6));
      sym_size      = (r < 25) ? 4'd0 : ((r > 96) ? 4'($urandom_range(12, 15))
                                                  : 4'($urandom_range(1, 11)));
      sym_amp       = 11'($urandom);
      block_ready   = ($urandom_range(0, 1) == 1);
      dc_pred_clear = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0; sym_valid = 1'b0; dc_pred_clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
